// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (D).
// One access in flight; D has priority, IF wins after STARVE_MAX losses.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_be_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_if_o,
    output logic        stall_d_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_e;

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);
    localparam logic [3:0] SC_MAX   = 4'(STARVE_MAX);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       owner_we_q, owner_we_d;
    logic [3:0] sc_q, sc_d;

    logic done;
    logic live;
    logic gnt_if;
    logic gnt_d;

    // State register; reset abandons any in-flight access
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            owner_we_q <= 1'b0;
            sc_q       <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_we_q <= owner_we_d;
            sc_q       <= sc_d;
        end
    end

    // Arbitration: live when idle or on the completion cycle
    always_comb begin
        done   = (state_q != IDLE) && (cnt_q == 3'd0);
        live   = !rst_i && ((state_q == IDLE) || done);
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (live) begin
            if (if_req_i && d_req_i) begin
                if (sc_q == SC_MAX) begin
                    gnt_if = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else begin
                gnt_if = if_req_i;
                gnt_d  = d_req_i;
            end
        end
    end

    // Next-state: new owner on a grant, else count down or go idle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_we_d = owner_we_q;
        sc_d       = sc_q;
        if (gnt_if || gnt_d) begin
            state_d    = gnt_if ? BUSY_IF : BUSY_D;
            cnt_d      = CNT_LOAD;
            owner_we_d = gnt_d & d_we_i;
        end else if (done) begin
            state_d = IDLE;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
        if (gnt_if) begin
            sc_d = 4'd0;
        end else if (gnt_d && if_req_i && (sc_q != SC_MAX)) begin
            sc_d = sc_q + 4'd1;
        end
    end

    // Outputs: grant-side memory mux and completion-side read return
    always_comb begin
        if_gnt_o    = gnt_if;
        d_gnt_o     = gnt_d;
        mem_en_o    = gnt_if | gnt_d;
        mem_we_o    = gnt_d & d_we_i;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        mem_be_o    = 4'd0;
        if (gnt_d) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_be_o    = d_be_i;
        end else if (gnt_if) begin
            mem_addr_o = if_addr_i;
        end
        if_rvalid_o = done && (state_q == BUSY_IF);
        d_rvalid_o  = done && (state_q == BUSY_D) && !owner_we_q;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'd0;
        d_rdata_o   = d_rvalid_o ? mem_rdata_i : 32'd0;
        stall_if_o  = if_req_i & ~gnt_if & ~rst_i;
        stall_d_o   = d_req_i & ~gnt_d & ~rst_i;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=2/SM=4, MEM_LAT=1/SM=2)
// checked every cycle against a cycle-arithmetic model, plus literal checks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] mem_rdata;

    logic [1:0]  if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [1:0]  mem_en, mem_we, stall_if, stall_d;
    logic [31:0] if_rdata [2];
    logic [31:0] d_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_be [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .MEM_LAT   (g == 0 ? 2 : 1),
            .STARVE_MAX(g == 0 ? 4 : 2)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .if_req_i   (if_req),
            .if_addr_i  (if_addr),
            .if_gnt_o   (if_gnt[g]),
            .if_rvalid_o(if_rvalid[g]),
            .if_rdata_o (if_rdata[g]),
            .d_req_i    (d_req),
            .d_we_i     (d_we),
            .d_addr_i   (d_addr),
            .d_wdata_i  (d_wdata),
            .d_be_i     (d_be),
            .d_gnt_o    (d_gnt[g]),
            .d_rvalid_o (d_rvalid[g]),
            .d_rdata_o  (d_rdata[g]),
            .mem_en_o   (mem_en[g]),
            .mem_we_o   (mem_we[g]),
            .mem_addr_o (mem_addr[g]),
            .mem_wdata_o(mem_wdata[g]),
            .mem_be_o   (mem_be[g]),
            .mem_rdata_i(mem_rdata),
            .stall_if_o (stall_if[g]),
            .stall_d_o  (stall_d[g])
        );
    end

    function automatic int lat(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int smax(int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: an access occupies the port from issue cycle iss to iss+LAT.
    // own: 0 = fetch, 1 = load, 2 = store
    bit act [2];
    int iss [2];
    int own [2];
    int sc [2];
    int cyc = 0;
    bit e_gi [2];
    bit e_gd [2];
    bit cmp [2];
    bit s_rst, s_ireq, s_dwe;

    initial begin
        for (int k = 0; k < 2; k++) begin
            act[k] = 0;
            iss[k] = 0;
            own[k] = 0;
            sc[k]  = 0;
        end
        forever begin
            @(negedge clk);
            s_rst  = rst;
            s_ireq = if_req;
            s_dwe  = d_we;
            for (int k = 0; k < 2; k++) begin
                bit lv, irv, drv;
                cmp[k] = act[k] && (cyc == iss[k] + lat(k));
                lv = !rst && (!act[k] || cmp[k]);
                e_gi[k] = 0;
                e_gd[k] = 0;
                if (lv && if_req && d_req) begin
                    if (sc[k] == smax(k)) e_gi[k] = 1;
                    else e_gd[k] = 1;
                end else if (lv) begin
                    e_gi[k] = if_req;
                    e_gd[k] = d_req;
                end
                irv = !rst && cmp[k] && own[k] == 0;
                drv = !rst && cmp[k] && own[k] == 1;
                chk($sformatf("if_gnt[%0d]", k), 32'(if_gnt[k]), 32'(e_gi[k]));
                chk($sformatf("d_gnt[%0d]", k), 32'(d_gnt[k]), 32'(e_gd[k]));
                chk($sformatf("mem_en[%0d]", k), 32'(mem_en[k]),
                    32'(e_gi[k] | e_gd[k]));
                chk($sformatf("mem_we[%0d]", k), 32'(mem_we[k]),
                    32'(e_gd[k] & d_we));
                chk($sformatf("mem_addr[%0d]", k), mem_addr[k],
                    e_gd[k] ? d_addr : (e_gi[k] ? if_addr : 32'd0));
                chk($sformatf("mem_wdata[%0d]", k), mem_wdata[k],
                    e_gd[k] ? d_wdata : 32'd0);
                chk($sformatf("mem_be[%0d]", k), 32'(mem_be[k]),
                    e_gd[k] ? 32'(d_be) : 32'd0);
                chk($sformatf("if_rvalid[%0d]", k), 32'(if_rvalid[k]), 32'(irv));
                chk($sformatf("if_rdata[%0d]", k), if_rdata[k],
                    irv ? mem_rdata : 32'd0);
                chk($sformatf("d_rvalid[%0d]", k), 32'(d_rvalid[k]), 32'(drv));
                chk($sformatf("d_rdata[%0d]", k), d_rdata[k],
                    drv ? mem_rdata : 32'd0);
                chk($sformatf("stall_if[%0d]", k), 32'(stall_if[k]),
                    32'(if_req & !e_gi[k] & !rst));
                chk($sformatf("stall_d[%0d]", k), 32'(stall_d[k]),
                    32'(d_req & !e_gd[k] & !rst));
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (s_rst) begin
                    act[k] = 0;
                    sc[k]  = 0;
                end else begin
                    if (e_gi[k] || e_gd[k]) begin
                        act[k] = 1;
                        iss[k] = cyc;
                        own[k] = e_gi[k] ? 0 : (s_dwe ? 2 : 1);
                    end else if (cmp[k]) begin
                        act[k] = 0;
                    end
                    if (e_gi[k]) sc[k] = 0;
                    else if (e_gd[k] && s_ireq && sc[k] < smax(k)) sc[k]++;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = $urandom;
    endtask

    task automatic idle(int n);
        if_req = 0;
        d_req  = 0;
        d_we   = 0;
        repeat (n) tick();
    endtask

    initial begin
        rst = 1; if_req = 1; d_req = 1; d_we = 0;
        if_addr = 32'h10; d_addr = 32'h20; d_wdata = 0; d_be = 0;
        mem_rdata = 0;
        // outputs held low during reset despite live requests
        repeat (3) begin
            tick();
            #3;
            chk("rst_if_gnt", 32'(if_gnt[0]), 0);
            chk("rst_mem_en", 32'(mem_en[0]), 0);
            chk("rst_stall_if", 32'(stall_if[0]), 0);
        end
        tick();
        rst = 0;
        idle(2);

        // single fetch
        tick(); if_req = 1; if_addr = 32'h100;
        #3;
        chk("sf_gnt", 32'(if_gnt[0]), 1);
        chk("sf_en", 32'(mem_en[0]), 1);
        chk("sf_addr", mem_addr[0], 32'h100);
        tick(); if_req = 0;
        tick(); mem_rdata = 32'hDEADBEEF;
        #3;
        chk("sf_rvalid", 32'(if_rvalid[0]), 1);
        chk("sf_rdata", if_rdata[0], 32'hDEADBEEF);
        tick();
        #3;
        chk("sf_rvalid_off", 32'(if_rvalid[0]), 0);
        idle(3);

        // simultaneous requests
        tick(); if_req = 1; if_addr = 32'h200; d_req = 1; d_addr = 32'h80;
        #3;
        chk("sim_dgnt", 32'(d_gnt[0]), 1);
        chk("sim_ignt0", 32'(if_gnt[0]), 0);
        chk("sim_stall0", 32'(stall_if[0]), 1);
        tick(); d_req = 0;
        #3;
        chk("sim_stall1", 32'(stall_if[0]), 1);
        tick();
        #3;
        chk("sim_drv", 32'(d_rvalid[0]), 1);
        chk("sim_ignt2", 32'(if_gnt[0]), 1);
        chk("sim_addr2", mem_addr[0], 32'h200);
        tick(); if_req = 0;
        tick();
        #3;
        chk("sim_irv4", 32'(if_rvalid[0]), 1);
        idle(3);

        // starvation override
        for (int c = 0; c <= 10; c++) begin
            tick();
            if_req = 1; if_addr = 32'h400 + 32'(c);
            d_req = 1; d_addr = 32'h500 + 32'(c);
            #3;
            chk($sformatf("stv_dgnt_c%0d", c), 32'(d_gnt[0]),
                32'((c % 2 == 0) && (c != 8)));
            chk($sformatf("stv_ignt_c%0d", c), 32'(if_gnt[0]), 32'(c == 8));
        end
        idle(3);

        // store with concurrent fetch
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h40;
        d_wdata = 32'h12345678; d_be = 4'hF;
        if_req = 1; if_addr = 32'h300;
        #3;
        chk("st_gnt", 32'(d_gnt[0]), 1);
        chk("st_we", 32'(mem_we[0]), 1);
        chk("st_be", 32'(mem_be[0]), 32'hF);
        chk("st_wdata", mem_wdata[0], 32'h12345678);
        tick(); d_req = 0; d_we = 0;
        #3;
        chk("st_drv1", 32'(d_rvalid[0]), 0);
        tick();
        #3;
        chk("st_drv2", 32'(d_rvalid[0]), 0);
        chk("st_ignt2", 32'(if_gnt[0]), 1);
        tick(); if_req = 0;
        idle(3);

        // reset mid-operation
        tick(); d_req = 1; d_addr = 32'h84;
        #3;
        chk("rm_gnt", 32'(d_gnt[0]), 1);
        tick(); rst = 1;
        #3;
        chk("rm_en", 32'(mem_en[0]), 0);
        chk("rm_dgnt", 32'(d_gnt[0]), 0);
        chk("rm_stall_d", 32'(stall_d[0]), 0);
        tick(); rst = 0; d_req = 0;
        #3;
        chk("rm_drv", 32'(d_rvalid[0]), 0);
        tick(); if_req = 1; if_addr = 32'h600;
        #3;
        chk("rm_ignt", 32'(if_gnt[0]), 1);
        tick(); if_req = 0;
        idle(3);

        // MEM_LAT=1 back-to-back fetches on instance 1
        for (int c = 0; c <= 5; c++) begin
            tick(); if_req = 1; if_addr = 32'h700 + 32'(4 * c);
            #3;
            chk($sformatf("b2b_gnt_c%0d", c), 32'(if_gnt[1]), 1);
            chk($sformatf("b2b_rv_c%0d", c), 32'(if_rvalid[1]), 32'(c >= 1));
        end
        idle(3);

        // randomized traffic, including occasional resets
        repeat (3000) begin
            tick();
            rst     = ($urandom_range(63) == 0);
            if_req  = ($urandom_range(3) != 0);
            d_req   = ($urandom_range(2) != 0);
            d_we    = $urandom_range(1);
            if_addr = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_be    = 4'($urandom);
        end
        rst = 0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
